// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider with start/done handshake and clock enable
// Ports: clock, reset (async, active-high), ce (freezes everything when 0), start,
//   dividend/divisor (captured on accept) -> quotient/remainder, busy, done (1-cycle
//   pulse, stretched while ce=0), div_by_zero.
// Define DIV_SIGNED_EN for two's-complement operands (adds a sign-fix cycle).
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, rem_q, rem_d, dsr_q, dsr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic busy_q, busy_d, done_q, done_d, dbz_q, dbz_d, zd_q, zd_d;
  logic [WIDTH:0] partial, trial;
  logic [WIDTH-1:0] rem_nx, acc_nx, zero_rem;
`ifdef DIV_SIGNED_EN
  logic sn_q, sn_d, sq_q, sq_d;
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction
  assign zero_rem = sn_q ? -acc_q : acc_q;
`else
  assign zero_rem = acc_q;
`endif
  // acc holds the unconsumed dividend bits on the left and the growing quotient on the right
  assign partial = {rem_q, acc_q[WIDTH-1]};
  assign trial   = partial - {1'b0, dsr_q};
  assign rem_nx  = trial[WIDTH] ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
  assign acc_nx  = {acc_q[WIDTH-2:0], ~trial[WIDTH]};
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = done_q;
    dbz_d       = dbz_q;
    zd_d        = zd_q;
`ifdef DIV_SIGNED_EN
    sn_d        = sn_q;
    sq_d        = sq_q;
`endif
    if (ce) begin
      unique case (state_q)
        IDLE: begin
          done_d = 1'b0;
          busy_d = start;
          if (start) begin
            dbz_d   = 1'b0;
            cnt_d   = '0;
            rem_d   = '0;
            zd_d    = divisor == '0;
            state_d = divisor == '0 ? DONE : CALC;
`ifdef DIV_SIGNED_EN
            acc_d   = mag(dividend);
            dsr_d   = mag(divisor);
            sn_d    = dividend[WIDTH-1];
            sq_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
`else
            acc_d   = dividend;
            dsr_d   = divisor;
`endif
          end
        end
        CALC: begin
          rem_d = rem_nx;
          acc_d = acc_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d = '0;
`ifdef DIV_SIGNED_EN
            state_d = FIX;
`else
            state_d     = DONE;
            quotient_d  = acc_nx;
            remainder_d = rem_nx;
`endif
          end
        end
`ifdef DIV_SIGNED_EN
        FIX: begin
          quotient_d  = sq_q ? -acc_q : acc_q;
          remainder_d = sn_q ? -rem_q : rem_q;
          state_d     = DONE;
        end
`endif
        DONE: begin
          // a zero divisor spends one extra DONE cycle so done lands two edges after accept
          if (zd_q && cnt_q == '0) cnt_d = CW'(1);
          else begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
            if (zd_q) begin
              quotient_d  = '1;
              remainder_d = zero_rem;
              dbz_d       = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      zd_q        <= 1'b0;
`ifdef DIV_SIGNED_EN
      sn_q        <= 1'b0;
      sq_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      dsr_q       <= dsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      zd_q        <= zd_d;
`ifdef DIV_SIGNED_EN
      sn_q        <= sn_d;
      sq_q        <= sq_d;
`endif
    end
  end
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven and directed checks of seq_divider (WIDTH=8)
module tb_seq_divider;
`ifdef DIV_SIGNED_EN
  localparam int L = 10;
`else
  localparam int L = 9;
`endif
  logic clock = 1'b0, reset = 1'b1, ce = 1'b1, start = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic [7:0] quotient, remainder;
  logic busy, done, div_by_zero;
  int checks = 0, failures = 0;
  seq_divider #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .ce(ce), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic [7:0] a, b, q, r;
    logic z;
    int lat;
  } vec_t;
  vec_t v[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic do_op(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] q, input logic [7:0] r, input logic z, input int lat);
    int n;
    dividend = a;
    divisor = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, " busy_at_accept"}, busy, 1);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk({name, " latency"}, n, lat);
    chk({name, " quotient"}, quotient, q);
    chk({name, " remainder"}, remainder, r);
    chk({name, " div_by_zero"}, div_by_zero, z);
    chk({name, " busy_with_done"}, busy, 1);
    tick();
    chk({name, " done_one_cycle"}, done, 0);
    chk({name, " busy_drops"}, busy, 0);
  endtask
  initial begin
    int n, cnt, at;
`ifdef DIV_SIGNED_EN
    v[0] = '{8'h9C, 8'd7,  8'hF2, 8'hFE, 1'b0, L};
    v[1] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, L};
    v[2] = '{8'd100, 8'hF9, 8'hF2, 8'd2, 1'b0, L};
    v[3] = '{8'h9C, 8'hF9, 8'd14, 8'hFE, 1'b0, L};
    v[4] = '{8'd7,  8'd0,  8'hFF, 8'd7,  1'b1, 2};
    v[5] = '{8'hFB, 8'd0,  8'hFF, 8'hFB, 1'b1, 2};
    v[6] = '{8'd100, 8'd7, 8'd14, 8'd2,  1'b0, L};
    v[7] = '{8'd127, 8'd1, 8'd127, 8'd0, 1'b0, L};
    v[8] = '{8'h80, 8'd3,  8'hD6, 8'hFE, 1'b0, L};
    v[9] = '{8'd0,  8'hFB, 8'd0,  8'd0,  1'b0, L};
`else
    v[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, L};
    v[1] = '{8'd200, 8'd0,   8'd255, 8'd200, 1'b1, 2};
    v[2] = '{8'd7,   8'd100, 8'd0,   8'd7,   1'b0, L};
    v[3] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, L};
    v[4] = '{8'd128, 8'd3,   8'd42,  8'd2,   1'b0, L};
    v[5] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, L};
    v[6] = '{8'd254, 8'd16,  8'd15,  8'd14,  1'b0, L};
    v[7] = '{8'd1,   8'd0,   8'd255, 8'd1,   1'b1, 2};
    v[8] = '{8'd255, 8'd2,   8'd127, 8'd1,   1'b0, L};
    v[9] = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0, L};
`endif
    tick();
    tick();
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset dbz", div_by_zero, 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) do_op($sformatf("vec%0d", i), v[i].a, v[i].b, v[i].q, v[i].r, v[i].z, v[i].lat);
    // start re-asserted while busy must not re-latch or add a second done
    dividend = 8'd255;
    divisor = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    at = -1;
    for (int e = 1; e <= 20; e++) begin
      if (e >= 2 && e <= 6) begin
        start = 1'b1;
        dividend = 8'd3;
        divisor = 8'd3;
      end else start = 1'b0;
      tick();
      if (done) begin
        cnt++;
        if (at < 0) begin
          at = e;
          chk("busy_start quotient", quotient, 8'd255);
          chk("busy_start remainder", remainder, 0);
        end
      end
    end
    chk("busy_start done_count", cnt, 1);
    chk("busy_start latency", at, L);
    // ce low for 3 cycles mid-CALC delays done by exactly 3
    dividend = 8'd100;
    divisor = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      if (n == 3) ce = 1'b0;
      if (n == 6) ce = 1'b1;
      tick();
      n++;
    end
    chk("ce_gap latency", n, L + 3);
    chk("ce_gap quotient", quotient, 14);
    chk("ce_gap remainder", remainder, 2);
    // done stretches while ce=0
    ce = 1'b0;
    tick();
    tick();
    chk("stretch done", done, 1);
    chk("stretch busy", busy, 1);
    ce = 1'b1;
    tick();
    chk("stretch release", done, 0);
    // async reset mid-CALC
    dividend = 8'd100;
    divisor = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 0; e < 4; e++) tick();
    reset = 1'b1;
    #1;
    chk("midreset busy", busy, 0);
    chk("midreset quotient", quotient, 0);
    chk("midreset remainder", remainder, 0);
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (done) cnt++;
    end
    chk("midreset no_done", cnt, 0);
    do_op("after_reset", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, L);
    // start held high: back-to-back accepts
    dividend = 8'd100;
    divisor = 8'd7;
    start = 1'b1;
    tick();
    dividend = 8'd9;
    divisor = 8'd3;
    at = -1;
    cnt = 0;
    for (int e = 1; e <= 2 * L + 3; e++) begin
      tick();
      if (done) begin
        cnt++;
        if (cnt == 1) begin
          chk("held first_at", e, L);
          chk("held first_q", quotient, 14);
        end
        if (cnt == 2) begin
          chk("held second_at", e, 2 * L + 1);
          chk("held second_q", quotient, 3);
          chk("held second_r", remainder, 0);
          start = 1'b0;
        end
      end
    end
    chk("held done_count", cnt, 2);
    start = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
